// File: rtl/bus_requester.sv
// Burst-write bus master front end: takes one command, requests the bus, streams beats while granted.
// Optional grant-wait timeout enabled by defining BUS_REQ_TIMEOUT_EN.
module bus_requester #(
    parameter int unsigned AW             = 8,
    parameter int unsigned DW             = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [3:0]    cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          req,
    input  logic          grant,
    output logic          bus_valid,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_data,
    output logic          bus_last,
    output logic          busy,
    output logic          err
);

`ifdef BUS_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] base;
    logic [3:0]    len;
    logic [3:0]    beat;
    logic [15:0]   wcnt;
    logic          cmd_fire;
    logic          beat_fire;
    logic          last_beat;
    logic          timeout;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = wr_valid & wr_ready;
    assign last_beat = (beat == len);
    // With the timeout disabled this folds to 0 and wcnt is left without loads.
    assign timeout   = TO_EN && (state == REQ) && !grant && (wcnt == TO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = REQ;
            REQ: begin
                if (grant) begin
                    state_nxt = XFER;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            XFER: if (beat_fire && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational handshake outputs
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            REQ:  busy      = 1'b1;
            XFER: begin
                busy     = 1'b1;
                wr_ready = grant;
            end
            default: ;
        endcase
    end

    // Command, counters, request and registered bus beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base      <= '0;
            len       <= '0;
            beat      <= '0;
            wcnt      <= '0;
            req       <= 1'b0;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            bus_valid <= beat_fire;
            bus_last  <= beat_fire & last_beat;
            err       <= timeout;
            if (beat_fire) begin
                bus_addr <= base + AW'(beat);
                bus_data <= wr_data;
                beat     <= beat + 4'd1;
                if (last_beat) req <= 1'b0;
            end
            if (cmd_fire) begin
                base <= cmd_addr;
                len  <= cmd_len;
                beat <= '0;
                wcnt <= '0;
                req  <= 1'b1;
            end else if (state == REQ && !grant) begin
                if (wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
                if (timeout) req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_requester.sv
// Scoreboard bench for bus_requester: expected beats queued by the stimulus, checked by a monitor.
module tb_bus_requester;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       req;
    logic       grant;
    logic       bus_valid;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_last;
    logic       busy;
    logic       err;
    logic       grant_allow;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    nbeats = 0;

    bus_requester #(.AW(8), .DW(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .req(req), .grant(grant),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data), .bus_last(bus_last),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-slot arbiter: grant follows req one cycle later while allowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) grant <= 1'b0;
        else     grant <= req & grant_allow;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the head of the expected queue
    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus_valid) begin
            nbeats++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected no beat at %0t",
                         bus_addr, bus_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_addr_data_last", 32'({bus_addr, bus_data, bus_last}), 32'(e));
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        check(name, 32'({req, bus_valid, bus_addr, bus_data, bus_last, err, busy}), 32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the handshake edge
    task automatic send_cmd(input logic [7:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("req_after_cmd", 32'(req), 32'd1);
        check("busy_after_cmd", 32'(busy), 32'd1);
    endtask

    // Feeds write data; optional wr_valid toggle, grant pause after beat pause_at, abort at stop_at
    task automatic stream(input logic [7:0] a, input logic [3:0] l, input logic [7:0] d0,
                          input bit toggle, input int pause_at, input int stop_at);
        int   sent       = 0;
        int   cyc        = 0;
        int   pause_left = 0;
        int   start      = nbeats;
        bit   paused     = 1'b0;
        logic fired      = 1'b0;
        while (sent <= int'(l) && cyc < 300) begin
            if (sent == stop_at) break;
            if (!paused && sent == pause_at) begin
                paused     = 1'b1;
                pause_left = 3;
            end
            grant_allow = (pause_left == 0);
            if (pause_left > 0) begin
                pause_left--;
                check("req_held_in_pause", 32'(req), 32'd1);
            end
            wr_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            wr_data  = d0 + 8'(sent);
            fired    = wr_valid & wr_ready;
            if (fired) begin
                exp_q.push_back('{addr: a + 8'(sent), data: d0 + 8'(sent), last: (sent == int'(l))});
                sent++;
            end
            @(negedge clk);
            cyc++;
            check("bus_valid_follows_handshake", 32'(bus_valid), 32'(fired));
        end
        wr_valid    = 1'b0;
        grant_allow = 1'b1;
        if (cyc >= 300) begin
            checks++;
            fails++;
            $display("FAIL burst_timeout: got %0d beats, expected %0d", sent, int'(l) + 1);
        end
        if (stop_at < 0) begin
            check("req_low_after_last", 32'(req), 32'd0);
            @(negedge clk);
            #1;
            check("beat_count", 32'(nbeats - start), 32'(int'(l) + 1));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("idle_after_burst", 32'({busy, cmd_ready}), 32'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        grant_allow = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset_release");

        // Basic 4-beat burst
        send_cmd(8'h10, 4'd3);
        stream(8'h10, 4'd3, 8'hA0, 1'b0, -1, -1);

        // Grant withdrawn for 3 cycles after beat 1
        send_cmd(8'h10, 4'd3);
        stream(8'h10, 4'd3, 8'hA0, 1'b0, 1, -1);

        // Address wrap
        send_cmd(8'hFE, 4'd3);
        stream(8'hFE, 4'd3, 8'h50, 1'b0, -1, -1);

        // Toggling write data valid
        send_cmd(8'h20, 4'd3);
        stream(8'h20, 4'd3, 8'hC0, 1'b1, -1, -1);

`ifdef BUS_REQ_TIMEOUT_EN
        grant_allow = 1'b0;
        send_cmd(8'h30, 4'd0);
        for (int i = 1; i <= 8; i++) begin
            check("timeout_wait", 32'({req, err, wr_ready}), 32'b100);
            @(negedge clk);
        end
        check("timeout_pulse", 32'({err, req, busy, wr_ready}), 32'b1000);
        @(negedge clk);
        check("timeout_pulse_end", 32'({err, req, busy}), 32'b000);
        grant_allow = 1'b1;
`else
        grant_allow = 1'b0;
        send_cmd(8'h30, 4'd0);
        for (int i = 0; i < 100; i++) begin
            check("req_waits", 32'({req, err, wr_ready}), 32'b100);
            @(negedge clk);
        end
        stream(8'h30, 4'd0, 8'h77, 1'b0, -1, -1);
`endif

        // Reset during a 16-beat burst after two beats
        send_cmd(8'h80, 4'd15);
        stream(8'h80, 4'd15, 8'h00, 1'b0, -1, 2);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_mid_burst");
        check("beats_before_reset", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_beat_after_reset", 32'({bus_valid, req, busy, wr_ready}), 32'b0000);
        end
        wr_valid = 1'b0;

        // Fresh command still works after reset
        send_cmd(8'h40, 4'd0);
        stream(8'h40, 4'd0, 8'h99, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_requester.md
# bus_requester

Master-side companion to the two-requester fixed-priority bus arbiter. It accepts one burst-write command at a time, raises `req`, and waits for `grant`. It then streams the burst's data beats onto the shared bus with registered outputs, pausing whenever `grant` is withdrawn. One instance sits in front of each peripheral master, with its `req`/`grant` pair wired to one arbiter slot.

## Interface
- `AW`, 8: bus address width.
- `DW`, 8: bus data width.
- `TIMEOUT_CYCLES`, 64: grant-wait limit. Used only with `BUS_REQ_TIMEOUT_EN`. Legal range 2..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_addr`  in  AW  burst start address.
- `cmd_len`  in  4  beats minus 1 (0 = 1 beat, 15 = 16 beats).
- `wr_valid`  in  1  write data available.
- `wr_ready`  out  1  write data consumed when high together with `wr_valid`.
- `wr_data`  in  DW  write data.
- `req`  out  1  bus request to the arbiter.
- `grant`  in  1  registered grant from the arbiter.
- `bus_valid`  out  1  beat on the bus this cycle.
- `bus_addr`  out  AW  beat address.
- `bus_data`  out  DW  beat data.
- `bus_last`  out  1  final beat of the burst.
- `busy`  out  1  a command is held (state is not IDLE).
- `err`  out  1  one-cycle timeout pulse.

## Operation
- States are IDLE, REQ and XFER. Registered state: `base`, `len`, beat counter `beat` (4 bits), wait counter `wcnt` (16 bits).
- IDLE:
  - `cmd_ready`=1 (combinational).
  - On a `cmd_valid` handshake: latch `cmd_addr` and `cmd_len`, clear `beat` and `wcnt`, set `req`<=1, go to REQ.
- REQ:
  - `req` stays 1.
  - `grant`=1 → go to XFER.
  - Otherwise `wcnt` increments, saturating at 0xFFFF.
- XFER:
  - `wr_ready` = `grant` (combinational, XFER only).
  - Beat cycle (`grant`=1 and `wr_valid`=1), registered next edge: `bus_valid`<=1, `bus_data`<=`wr_data`, `bus_addr`<=`base`+`beat` (mod 2^AW), `bus_last`<=(`beat`==`len`); `beat` increments.
  - Any other cycle: `bus_valid`<=0 and `bus_last`<=0; `bus_addr`/`bus_data` hold.
  - Grant loss mid-burst: `req` stays 1 and beats pause. The burst resumes at the same `beat` when `grant` returns, with no wait limit in XFER.
  - On the last beat: `req`<=0, go to IDLE.
- After a burst, `req` stays low for at least 1 cycle because `cmd_ready` is only valid in IDLE.
- A beat is never issued outside XFER. `wr_ready` is 0 outside XFER.
- `busy` = (state != IDLE).

## Timing
- Reset values: `req`=0, `bus_valid`=0, `bus_addr`=0, `bus_data`=0, `bus_last`=0, `err`=0, `busy`=0; state=IDLE.
- Reset asserted mid-burst abandons the burst immediately; no further beats are issued after deassertion.
- Command handshake at edge N → `req`=1 from N.
- The arbiter's registered grant means `grant` is first high after edge N+1, so XFER is entered at N+2.
- First beat handshake in the cycle after N+2 → `bus_valid`=1 after edge N+3.
- Uninterrupted burst: L+1 consecutive `bus_valid` cycles. `bus_last` is high only on the final one. `req` falls on the same edge that registers the last beat.
- `grant` dropping at a clock edge stops beats in that cycle, with zero extra beats. The arbiter guarantees the bus is not driven while ungranted.

## Configuration
- `BUS_REQ_TIMEOUT_EN` defined:
  - In REQ, when `wcnt` reaches `TIMEOUT_CYCLES`-1 with `grant`=0: `req`<=0, `err`<=1 for exactly one cycle, command discarded, go to IDLE.
  - No write data is consumed by the discarded command.
  - Grant on the same cycle as the limit wins: go to XFER, no `err`.
- `BUS_REQ_TIMEOUT_EN` undefined: `err` is tied 0 and REQ waits indefinitely. `wcnt` may be optimised away.

## Test plan
- Command addr=0x10, len=3; `grant` 1 cycle after `req`; `wr_valid` held with data A0..A3 → 4 back-to-back beats at 0x10..0x13 with A0..A3, `bus_last` on 0x13, `req` low after the last beat.
- Same burst, `grant` forced low for 3 cycles after beat 1 → beats pause, `req` stays 1, resume at 0x12, total of exactly 4 beats.
- addr=0xFE, len=3 → addresses 0xFE, 0xFF, 0x00, 0x01.
- `wr_valid` toggling 1,0,1,0 in XFER with `grant`=1 → a beat only on cycles with `wr_valid`=1; `bus_valid`=0 otherwise.
- With `BUS_REQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `grant` tied 0 → `err` one-cycle pulse after 8 REQ cycles, `req`=0, `busy`=0, no `wr_ready`. Without the macro, `req` stays 1 for 100 cycles and `err` stays 0.
- Assert `rst` after beat 2 of a 16-beat burst → all outputs 0 asynchronously. After release, no beats until a new command.
